// File: rtl/load_seq_pkg.sv
// Shared types and default timing constants for the tile load sequencer.
package load_seq_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StLoadReq,
      StCapture,
      StAdv,
      StFeedLoad,
      StFeed,
      StDrain,
      StWrap,
      StDone
   } state_e;

   localparam int unsigned BEATS_DEF        = 4;
   localparam int unsigned FEED_CYCLES_DEF  = 7;
   localparam int unsigned DRAIN_CYCLES_DEF = 3;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/load_sequencer.sv
// Control FSM: loads one 4x4 tile beat by beat, then feeds, drains and rewinds the
// datapath row/column counters before signalling completion.
module load_sequencer
   import load_seq_pkg::*;
#(
   parameter int unsigned BEATS        = BEATS_DEF,
   parameter int unsigned FEED_CYCLES  = FEED_CYCLES_DEF,
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic tx_one_done,
   input  logic load_in_done,
   output logic dest_ready,
   output logic next_row,
   output logic next_col,
   output logic load_streams,
   output logic shift_en,
   output logic acc_clear,
   output logic busy,
   output logic done,
   output logic seq_err
);

   localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned CntW  = $clog2(max_u(FEED_CYCLES, DRAIN_CYCLES) + 1);

   state_e           r_state,   w_state_d;
   logic [BeatW-1:0] r_beat,    w_beat_d;
   logic [CntW-1:0]  r_cnt,     w_cnt_d;
   logic             r_seq_err, w_seq_err_d;
   logic             r_first,   w_first_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_beat    <= '0;
         r_cnt     <= '0;
         r_seq_err <= 1'b0;
         r_first   <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_beat    <= w_beat_d;
         r_cnt     <= w_cnt_d;
         r_seq_err <= w_seq_err_d;
         r_first   <= w_first_d;
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_beat_d    = r_beat;
      w_cnt_d     = r_cnt;
      w_seq_err_d = r_seq_err;
      w_first_d   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_state_d = StLoadReq;
               w_first_d = 1'b1;
            end
         end
         StLoadReq: begin
            if (tx_one_done) w_state_d = StCapture;
         end
         StCapture: begin
            if (r_beat == BeatW'(BEATS - 1)) begin
               // Datapath counters must agree with our beat count on the final beat.
               if (!load_in_done) w_seq_err_d = 1'b1;
               w_state_d = StFeedLoad;
            end else begin
               w_state_d = StAdv;
            end
         end
         StAdv: begin
            w_beat_d  = r_beat + BeatW'(1);
            w_state_d = StLoadReq;
         end
         StFeedLoad: begin
            w_cnt_d   = '0;
            w_state_d = StFeed;
         end
         StFeed: begin
            if (r_cnt == CntW'(FEED_CYCLES - 1)) begin
               w_cnt_d   = '0;
               w_state_d = StDrain;
            end else begin
               w_cnt_d = r_cnt + CntW'(1);
            end
         end
         StDrain: begin
            if (r_cnt == CntW'(DRAIN_CYCLES - 1)) begin
               w_cnt_d   = '0;
               w_state_d = StWrap;
            end else begin
               w_cnt_d = r_cnt + CntW'(1);
            end
         end
         StWrap: begin
            w_beat_d  = '0;
            w_state_d = StDone;
         end
         StDone: begin
            if (start) begin
               w_state_d = StLoadReq;
               w_first_d = 1'b1;
            end else begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // WRAP supplies the fourth counter pulse, returning the datapath counters to 0.
   assign dest_ready   = (r_state == StLoadReq);
   assign next_row     = (r_state == StAdv) || (r_state == StWrap);
   assign next_col     = next_row;
   assign load_streams = (r_state == StFeedLoad);
   assign shift_en     = (r_state == StFeed);
   assign acc_clear    = (r_state == StLoadReq) && r_first;
   assign busy         = (r_state != StIdle);
   assign done         = (r_state == StDone);
   assign seq_err      = r_seq_err;

endmodule
